// File: rtl/dma_axi_mem_slave.sv
// AXI4 slave memory behind the DMA master port: independent read and write channels,
// one outstanding burst per direction, SLVERR for out-of-range beats and unsupported bursts.
module dma_axi_mem_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned MEM_WORDS  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_awid,
  input  logic [ADDR_WIDTH-1:0]   s_awaddr,
  input  logic [7:0]              s_awlen,
  input  logic [2:0]              s_awsize,
  input  logic [1:0]              s_awburst,
  input  logic                    s_awvalid,
  output logic                    s_awready,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wlast,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [ID_WIDTH-1:0]     s_bid,
  output logic [1:0]              s_bresp,
  output logic                    s_bvalid,
  input  logic                    s_bready,
  input  logic [ID_WIDTH-1:0]     s_arid,
  input  logic [ADDR_WIDTH-1:0]   s_araddr,
  input  logic [7:0]              s_arlen,
  input  logic [2:0]              s_arsize,
  input  logic [1:0]              s_arburst,
  input  logic                    s_arvalid,
  output logic                    s_arready,
  output logic [ID_WIDTH-1:0]     s_rid,
  output logic [DATA_WIDTH-1:0]   s_rdata,
  output logic [1:0]              s_rresp,
  output logic                    s_rlast,
  output logic                    s_rvalid,
  input  logic                    s_rready
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned SIZE_MAX   = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_WIDTH  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH + 1)'(MEM_WORDS * STRB_WIDTH);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] BurstFixed = 2'd0;
  localparam logic [1:0] BurstIncr  = 2'd1;

  // An address below BASE_ADDR borrows into the extra bit and so never compares below SPAN.
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH:0] off;
    off = {1'b0, addr} - {1'b0, BASE_ADDR};
    return off < SPAN;
  endfunction

  function automatic logic [IDX_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = (addr - BASE_ADDR) >> SIZE_MAX;
    return off[IDX_WIDTH-1:0];
  endfunction

  function automatic logic burst_err(input logic [1:0] burst, input logic [2:0] size);
    return ((burst != BurstFixed) && (burst != BurstIncr)) || (32'(size) > SIZE_MAX);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                      input logic [1:0] burst,
                                                      input logic [2:0] size);
    if (burst == BurstFixed) return addr;
    return addr + (ADDR_WIDTH'(1) << size);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  w_state_e w_state_q, w_state_d;

  logic [ID_WIDTH-1:0]   w_id_q;
  logic [ADDR_WIDTH-1:0] w_addr_q;
  logic [7:0]            w_len_q;
  logic [2:0]            w_size_q;
  logic [1:0]            w_burst_q;
  logic                  w_berr_q;
  logic                  w_err_q;
  logic [7:0]            w_cnt_q;

  logic aw_fire, w_fire, b_fire;
  logic w_last_beat, w_mem_ok, w_beat_err;

  assign aw_fire     = s_awvalid && s_awready;
  assign w_fire      = s_wvalid && s_wready;
  assign b_fire      = s_bvalid && s_bready;
  assign w_last_beat = (w_cnt_q == w_len_q);
  assign w_mem_ok    = !w_berr_q && in_range(w_addr_q);
  assign w_beat_err  = !w_mem_ok || (w_last_beat != s_wlast);

  always_ff @(posedge clk) begin
    if (rst) w_state_q <= WIdle;
    else     w_state_q <= w_state_d;
  end

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      WIdle:   if (aw_fire) w_state_d = WData;
      WData:   if (w_fire && w_last_beat) w_state_d = WResp;
      WResp:   if (b_fire) w_state_d = WIdle;
      default: w_state_d = WIdle;
    endcase
  end

  // Outputs are forced low during reset, including the first cycle rst is seen.
  always_comb begin
    s_awready = 1'b0;
    s_wready  = 1'b0;
    s_bvalid  = 1'b0;
    s_bresp   = RespOkay;
    s_bid     = '0;
    if (!rst) begin
      s_awready = (w_state_q == WIdle);
      s_wready  = (w_state_q == WData);
      s_bvalid  = (w_state_q == WResp);
      s_bresp   = (s_bvalid && w_err_q) ? RespSlverr : RespOkay;
      s_bid     = w_id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_berr_q  <= 1'b0;
      w_err_q   <= 1'b0;
      w_cnt_q   <= '0;
    end else begin
      if (aw_fire) begin
        w_id_q    <= s_awid;
        w_addr_q  <= s_awaddr;
        w_len_q   <= s_awlen;
        w_size_q  <= s_awsize;
        w_burst_q <= s_awburst;
        w_berr_q  <= burst_err(s_awburst, s_awsize);
        w_err_q   <= 1'b0;
        w_cnt_q   <= '0;
      end
      if (w_fire) begin
        w_addr_q <= next_addr(w_addr_q, w_burst_q, w_size_q);
        w_cnt_q  <= w_cnt_q + 8'd1;
        if (w_beat_err) w_err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fire && w_mem_ok) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (s_wstrb[b]) mem[word_idx(w_addr_q)][b*8 +: 8] <= s_wdata[b*8 +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  typedef enum logic [0:0] {RIdle, RData} r_state_e;
  r_state_e r_state_q, r_state_d;

  logic [ID_WIDTH-1:0]   r_id_q;
  logic [ADDR_WIDTH-1:0] r_addr_q;  // address of the next beat to load
  logic [7:0]            r_len_q;
  logic [2:0]            r_size_q;
  logic [1:0]            r_burst_q;
  logic                  r_berr_q;
  logic [7:0]            r_cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  logic                  ar_fire, r_fire, r_last_beat, r_load, r_load_ok;
  logic [ADDR_WIDTH-1:0] r_load_addr;

  assign ar_fire     = s_arvalid && s_arready;
  assign r_fire      = s_rvalid && s_rready;
  assign r_last_beat = (r_cnt_q == r_len_q);
  assign r_load      = ar_fire || (r_fire && !r_last_beat);
  assign r_load_addr = ar_fire ? s_araddr : r_addr_q;
  assign r_load_ok   = !(ar_fire ? burst_err(s_arburst, s_arsize) : r_berr_q) &&
                       in_range(r_load_addr);

  always_ff @(posedge clk) begin
    if (rst) r_state_q <= RIdle;
    else     r_state_q <= r_state_d;
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      RIdle:   if (ar_fire) r_state_d = RData;
      RData:   if (r_fire && r_last_beat) r_state_d = RIdle;
      default: r_state_d = RIdle;
    endcase
  end

  always_comb begin
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    s_rdata   = '0;
    s_rresp   = RespOkay;
    s_rid     = '0;
    if (!rst) begin
      s_arready = (r_state_q == RIdle);
      s_rvalid  = (r_state_q == RData);
      s_rlast   = s_rvalid && r_last_beat;
      s_rdata   = rdata_q;
      s_rresp   = rresp_q;
      s_rid     = r_id_q;
    end
  end

  // The load reads memory combinationally, so a same-cycle write to that word is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_berr_q  <= 1'b0;
      r_cnt_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= RespOkay;
    end else begin
      if (ar_fire) begin
        r_id_q    <= s_arid;
        r_len_q   <= s_arlen;
        r_size_q  <= s_arsize;
        r_burst_q <= s_arburst;
        r_berr_q  <= burst_err(s_arburst, s_arsize);
        r_cnt_q   <= '0;
        r_addr_q  <= next_addr(s_araddr, s_arburst, s_arsize);
      end else if (r_fire && !r_last_beat) begin
        r_cnt_q  <= r_cnt_q + 8'd1;
        r_addr_q <= next_addr(r_addr_q, r_burst_q, r_size_q);
      end
      if (r_load) begin
        rdata_q <= r_load_ok ? mem[word_idx(r_load_addr)] : '0;
        rresp_q <= r_load_ok ? RespOkay : RespSlverr;
      end
    end
  end

endmodule
